// File: rtl/rcv_ctrl.sv
// UART receive-path controller: line sync, start detect, bit-centre strobes.
// Optional false-start rejection at the start-bit centre: RCV_CTRL_START_CHECK_EN.
module rcv_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int NMAX = HALF + (DATA_BITS + 1) * CLKS_PER_BIT;
  localparam int NW   = $clog2(NMAX + 1);
  localparam int BW   = $clog2(DATA_BITS + 2);

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    STOP_CHK,
    LOAD
  } state_t;

  state_t state, state_n;

  logic sync1, sync2, prev;
  logic start_edge;
  logic [NW-1:0] n;
  logic [NW-1:0] tgt;
  logic [BW-1:0] bcnt;
  logic strobe;
  logic last;
  logic false_start;
  logic accept;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign start_edge = prev & ~sync2;
  assign accept     = (state == IDLE) && start_edge;
  assign strobe     = (state == RECEIVE) && (n == tgt);
  assign last       = (bcnt == BW'(DATA_BITS));

`ifdef RCV_CTRL_START_CHECK_EN
  // line back high at start-bit centre: treat as noise
  assign false_start = (n == NW'(HALF)) && sync2;
`else
  assign false_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start_edge) state_n = RECEIVE;
      end
      RECEIVE: begin
        if (false_start) begin
          state_n = IDLE;
        end else if (strobe && last) begin
          state_n = STOP_CHK;
        end
      end
      STOP_CHK: begin
        state_n = stop_bit ? LOAD : IDLE;
      end
      LOAD: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // tgt tracks the next bit-centre count; frozen after the stop strobe
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      n    <= '0;
      tgt  <= '0;
      bcnt <= '0;
    end else if (accept) begin
      n    <= '0;
      tgt  <= NW'(HALF + CLKS_PER_BIT);
      bcnt <= '0;
    end else if (state == RECEIVE) begin
      n <= n + NW'(1);
      if (strobe && !last) begin
        bcnt <= bcnt + BW'(1);
        tgt  <= tgt + NW'(CLKS_PER_BIT);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      framing_error <= 1'b0;
    end else if (accept) begin
      framing_error <= 1'b0;
    end else if (state == STOP_CHK && !stop_bit) begin
      framing_error <= 1'b1;
    end
  end

  always_comb begin
    shift_strobe = strobe;
    load_buffer  = 1'b0;
    rx_busy      = 1'b1;
    unique case (1'b1)
      (state == IDLE): rx_busy     = 1'b0;
      (state == LOAD): load_buffer = 1'b1;
      default: ;
    endcase
  end

endmodule
